sort_pkt_loader: RTL and testbench
==================================

// Module: sort_pkt_loader
// PURPOSE
//  Upstream stage of the packet sorter. Accepts one packet at a time from an
//  Avalon-ST-style input and writes it word by word into the sorter's dual-port
//  RAM via port A. It then drives last_addr and a one-cycle start pulse to the
//  in-place sorter, waits for sort completion, and holds off new input until the
//  downstream reader reports the RAM drained.
// PARAMETERS
//  DWIDTH       8   data word width, bits
//  MAX_PKT_LEN  16  RAM depth in words; AWIDTH = $clog2(MAX_PKT_LEN)
// PORTS
//  clk_i              in   1       clock
//  arst_n_i           in   1       async reset, active low
//  snk_data_i         in   DWIDTH  packet word
//  snk_startofpacket_i in  1       first word of packet
//  snk_endofpacket_i  in   1       last word of packet
//  snk_valid_i        in   1       word valid
//  snk_ready_o        out  1       loader accepts word (transfer = valid & ready)
//  ram_data_o         out  DWIDTH  RAM port A write data
//  ram_addr_o         out  AWIDTH  RAM port A address
//  ram_we_o           out  1       RAM port A write enable
//  last_addr_o        out  AWIDTH  address of last stored word, to sorter
//  start_sorting_o    out  1       one-cycle pulse, to sorter
//  end_sorting_i      in   1       sorter idle/done level
//  pkt_ready_o        out  1       one-cycle pulse: sorted packet available
//  drain_done_i       in   1       one-cycle pulse from reader: RAM free
//  pkt_ovf_o          out  1       last packet truncated; valid with pkt_ready_o
// BEHAVIOUR
//  Reset (async, arst_n_i=0): state IDLE, all outputs 0, wr_addr 0.
//  FSM: IDLE -> LOAD -> START -> SORT -> HOLD -> IDLE.
//  IDLE: snk_ready_o=1. Transfer with sop: write word at addr 0; if eop also,
//    go START (1-word packet, last_addr 0), else LOAD. Transfers without sop
//    are consumed and discarded.
//  LOAD: snk_ready_o=1. Each transfer writes at wr_addr+1 combinationally
//    (ram_we_o = transfer, zero extra latency). On eop: last_addr_o <= address
//    of last written word, go START.
//  sop in LOAD: restart packet, word written at addr 0, earlier words dropped.
//  Overflow: words past index MAX_PKT_LEN-1 not written (ram_we_o=0), still
//    accepted until eop; last_addr_o = MAX_PKT_LEN-1, ovf flag set.
//    wr_addr saturates, never wraps.
//  START: snk_ready_o=0, start_sorting_o=1 for exactly this cycle; -> SORT.
//  SORT: end_sorting_i sampled starting the cycle after START (value during
//    START ignored). When 1: pkt_ready_o=1 for one cycle, pkt_ovf_o valid
//    that cycle; -> HOLD.
//  HOLD: snk_ready_o=0, ram_we_o=0; on drain_done_i -> IDLE. drain_done_i
//    in any other state ignored.
//  last_addr_o stable from START through HOLD; pkt_ovf_o cleared on next sop.
//  Input to ready latency: snk_ready_o is a registered state decode.
// CONFIGURATION
//  SORT_LOADER_STATS_EN defined: adds outputs pkt_cnt_o[31:0] (packets handed
//    to sorter) and drop_cnt_o[31:0] (words discarded: overflow, orphan,
//    restart); both reset 0, saturate at all-ones.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Package sort_pkg: state enum sort_ldr_state_t, AWIDTH helper function,
//    shared with sorter and reader. Single module, no sub-modules.
// TESTING
//  5-word pkt 3,1,4,1,5 -> writes addr 0..4, last_addr_o=4, one start pulse.
//  1-word pkt (sop&eop) 0x7 -> addr 0 written, last_addr_o=0, start pulse.
//  20-word pkt, MAX_PKT_LEN=16 -> 16 writes, last_addr_o=15, pkt_ovf_o=1.
//  end_sorting_i tied 1 -> pkt_ready_o asserted 2 cycles after start pulse.
//  valid without sop in IDLE -> no writes; sop mid-LOAD -> restart at 0.
//  arst_n_i low mid-LOAD -> outputs 0 same cycle; next packet loads at addr 0.

Source files
------------

// File: rtl/sort_pkt_loader_pkg.sv
// Shared types for the packet sorter: FSM state encoding and RAM address-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   sort_ldr_state_t  loader FSM state (IDLE/LOAD/START/SORT/HOLD)
//   addr_width()      RAM address width for a given depth, never below 1 bit
//   DEF_*             default geometry shared by loader, sorter and reader
package sort_pkg;

    localparam int DEF_DWIDTH      = 8;
    localparam int DEF_MAX_PKT_LEN = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        SORT  = 3'd3,
        HOLD  = 3'd4
    } sort_ldr_state_t;

    // A one-word RAM still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sort_pkt_loader_if.sv
// Avalon-ST style packet stream carried from the source into the sorter loader.
// Latency: n/a (wires only).
// Backpressure: a word moves only in a cycle where snk_valid and snk_ready are both high.
//
// Signals: snk_data, snk_startofpacket, snk_endofpacket, snk_valid (source -> loader);
//          snk_ready (loader -> source).
// Modports: master = packet source, slave = loader.
interface sort_pkt_loader_if #(
    parameter int DWIDTH = 8
) ();
    logic [DWIDTH-1:0] snk_data;
    logic              snk_startofpacket;
    logic              snk_endofpacket;
    logic              snk_valid;
    logic              snk_ready;

    modport master (
        output snk_data, snk_startofpacket, snk_endofpacket, snk_valid,
        input  snk_ready
    );

    modport slave (
        input  snk_data, snk_startofpacket, snk_endofpacket, snk_valid,
        output snk_ready
    );
endinterface

// File: rtl/sort_pkt_loader.sv
// Loads one packet into the sorter RAM (port A), pulses start, waits for sort done, then for drain.
// Latency: RAM write is combinational from the accepted word; start pulse one cycle after eop accept.
// Backpressure: snk_ready is a registered state decode, high only in IDLE/LOAD; low from START until drained.
//
// Ports: clk_i, arst_n_i (async, active low); snk (stream slave); ram_data_o/ram_addr_o/ram_we_o (RAM port A);
//        last_addr_o, start_sorting_o, end_sorting_i (sorter); pkt_ready_o, pkt_ovf_o, drain_done_i (reader).
// Build option SORT_LOADER_STATS_EN adds pkt_cnt_o (packets handed to sorter) and drop_cnt_o (words discarded).
module sort_pkt_loader
    import sort_pkg::*;
#(
    parameter  int DWIDTH      = DEF_DWIDTH,
    parameter  int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
    localparam int AWIDTH      = addr_width(MAX_PKT_LEN)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    sort_pkt_loader_if.slave  snk,
    output logic [DWIDTH-1:0] ram_data_o,
    output logic [AWIDTH-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [AWIDTH-1:0] last_addr_o,
    output logic              start_sorting_o,
    input  logic              end_sorting_i,
    output logic              pkt_ready_o,
    input  logic              drain_done_i,
`ifdef SORT_LOADER_STATS_EN
    output logic              pkt_ovf_o,
    output logic [31:0]       pkt_cnt_o,
    output logic [31:0]       drop_cnt_o
`else
    output logic              pkt_ovf_o
`endif
);

    localparam logic [AWIDTH-1:0] ADDR_MAX = AWIDTH'(MAX_PKT_LEN - 1);

    sort_ldr_state_t   r_state;
    logic [AWIDTH-1:0] r_wr_addr;   // address of the most recently written word
    logic [AWIDTH-1:0] r_last_addr;
    logic              r_ready;
    logic              r_start;
    logic              r_pkt_ready;
    logic              r_ovf;

    logic              w_xfer;
    logic              w_sop;
    logic              w_full;
    logic              w_we;
    logic [AWIDTH-1:0] w_next_addr;
    logic [AWIDTH-1:0] w_addr;

    // r_ready is only ever high in IDLE/LOAD, so any transfer implies one of those states.
    assign w_xfer      = snk.snk_valid & r_ready;
    assign w_sop       = w_xfer & snk.snk_startofpacket;
    assign w_full      = (r_wr_addr == ADDR_MAX);
    assign w_next_addr = r_wr_addr + AWIDTH'(1);

    // A sop always (re)starts at address 0; mid-packet words append until the RAM is full,
    // after which they are swallowed without a write so wr_addr never wraps.
    always_comb begin
        w_we   = 1'b0;
        w_addr = '0;
        if (w_sop) begin
            w_we = 1'b1;
        end else if (w_xfer && (r_state == LOAD) && !w_full) begin
            w_we   = 1'b1;
            w_addr = w_next_addr;
        end
    end

    assign ram_we_o        = w_we;
    assign ram_addr_o      = w_addr;
    assign ram_data_o      = w_we ? snk.snk_data : '0;
    assign snk.snk_ready   = r_ready;
    assign last_addr_o     = r_last_addr;
    assign start_sorting_o = r_start;
    assign pkt_ready_o     = r_pkt_ready;
    assign pkt_ovf_o       = r_ovf;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state     <= IDLE;
            r_wr_addr   <= '0;
            r_last_addr <= '0;
            r_ready     <= 1'b0;
            r_start     <= 1'b0;
            r_pkt_ready <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_pkt_ready <= 1'b0;
            if (w_sop) begin
                // New packet (from IDLE, or a restart that drops the partial one in LOAD).
                r_wr_addr <= '0;
                r_ovf     <= 1'b0;
                if (snk.snk_endofpacket) begin
                    r_last_addr <= '0;
                    r_state     <= START;
                    r_ready     <= 1'b0;
                    r_start     <= 1'b1;
                end else begin
                    r_state <= LOAD;
                    r_ready <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: r_ready <= 1'b1;  // orphan words are consumed without effect
                    LOAD: begin
                        if (w_xfer) begin
                            if (w_full) r_ovf     <= 1'b1;
                            else        r_wr_addr <= w_next_addr;
                            if (snk.snk_endofpacket) begin
                                r_last_addr <= w_full ? ADDR_MAX : w_next_addr;
                                r_state     <= START;
                                r_ready     <= 1'b0;
                                r_start     <= 1'b1;
                            end
                        end
                    end
                    // end_sorting_i during START may still show the previous idle level.
                    START: r_state <= SORT;
                    SORT: begin
                        if (end_sorting_i) begin
                            r_pkt_ready <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (drain_done_i) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SORT_LOADER_STATS_EN
    logic [31:0]       r_pkt_cnt;
    logic [31:0]       r_drop_cnt;
    logic [AWIDTH:0]   w_drop_inc;
    logic [32:0]       w_drop_sum;

    // Discarded words: orphans in IDLE, overflow words, and every word written before a restart.
    always_comb begin
        w_drop_inc = '0;
        if (w_xfer) begin
            if ((r_state == IDLE) && !snk.snk_startofpacket)
                w_drop_inc = (AWIDTH+1)'(1);
            else if ((r_state == LOAD) && snk.snk_startofpacket)
                w_drop_inc = {1'b0, r_wr_addr} + (AWIDTH+1)'(1);
            else if ((r_state == LOAD) && w_full)
                w_drop_inc = (AWIDTH+1)'(1);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + 33'(w_drop_inc);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_start && (r_pkt_cnt != '1))
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            r_drop_cnt <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
        end
    end

    assign pkt_cnt_o  = r_pkt_cnt;
    assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_sort_pkt_loader.sv
module tb_sort_pkt_loader;

    logic       clk_i = 1'b0;
    logic       arst_n_i = 1'b1;
    logic [7:0] ram_data;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [3:0] last_addr;
    logic       start_sorting;
    logic       end_sorting = 1'b0;
    logic       pkt_ready;
    logic       drain_done = 1'b0;
    logic       pkt_ovf;
`ifdef SORT_LOADER_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sort_pkt_loader_if #(.DWIDTH(8)) snk_if ();

    sort_pkt_loader #(.DWIDTH(8), .MAX_PKT_LEN(16)) dut (
        .clk_i           (clk_i),
        .arst_n_i        (arst_n_i),
        .snk             (snk_if),
        .ram_data_o      (ram_data),
        .ram_addr_o      (ram_addr),
        .ram_we_o        (ram_we),
        .last_addr_o     (last_addr),
        .start_sorting_o (start_sorting),
        .end_sorting_i   (end_sorting),
        .pkt_ready_o     (pkt_ready),
        .drain_done_i    (drain_done),
`ifdef SORT_LOADER_STATS_EN
        .pkt_ovf_o       (pkt_ovf),
        .pkt_cnt_o       (pkt_cnt),
        .drop_cnt_o      (drop_cnt)
`else
        .pkt_ovf_o       (pkt_ovf)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       vld, sop, eop;
        logic [7:0] dat;
        logic       es, dd;
        logic       rdy, we;
        logic [3:0] addr;
        logic [7:0] wdat;
        logic       st, pr;
        logic [3:0] last;
        logic       ovf;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t v(input logic vld, sop, eop, input logic [7:0] dat, input logic es, dd,
                               input logic rdy, we, input logic [3:0] addr, input logic [7:0] wdat,
                               input logic st, pr, input logic [3:0] last, input logic ovf);
        vec_t r;
        r.vld = vld; r.sop = sop; r.eop = eop; r.dat = dat; r.es = es; r.dd = dd;
        r.rdy = rdy; r.we = we; r.addr = addr; r.wdat = wdat; r.st = st; r.pr = pr;
        r.last = last; r.ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, sop, eop, input logic [7:0] dat, input logic es, dd);
        snk_if.snk_valid         = vld;
        snk_if.snk_startofpacket = sop;
        snk_if.snk_endofpacket   = eop;
        snk_if.snk_data          = dat;
        end_sorting              = es;
        drain_done               = dd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rdy"},  32'(snk_if.snk_ready), 0);
        chk({tag, ".we"},   32'(ram_we), 0);
        chk({tag, ".addr"}, 32'(ram_addr), 0);
        chk({tag, ".data"}, 32'(ram_data), 0);
        chk({tag, ".st"},   32'(start_sorting), 0);
        chk({tag, ".pr"},   32'(pkt_ready), 0);
        chk({tag, ".last"}, 32'(last_addr), 0);
        chk({tag, ".ovf"},  32'(pkt_ovf), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int writes;
        int lat;

        //          vld sop eop dat    es dd | rdy we addr wdat  st pr last ovf
        vecs[0]  = v(1, 0, 0, 8'hAA, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0); // orphan in IDLE
        vecs[1]  = v(1, 0, 1, 8'hBB, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0); // orphan with eop
        vecs[2]  = v(1, 1, 0, 8'h03, 0, 0,  1, 1, 0, 8'h03, 0, 0, 0, 0); // pkt 3,1,4,1,5
        vecs[3]  = v(0, 0, 0, 8'h09, 0, 1,  1, 0, 0, 8'h00, 0, 0, 0, 0); // bubble, drain ignored
        vecs[4]  = v(1, 0, 0, 8'h01, 0, 0,  1, 1, 1, 8'h01, 0, 0, 0, 0);
        vecs[5]  = v(1, 0, 0, 8'h04, 0, 0,  1, 1, 2, 8'h04, 0, 0, 0, 0);
        vecs[6]  = v(1, 0, 0, 8'h01, 0, 0,  1, 1, 3, 8'h01, 0, 0, 0, 0);
        vecs[7]  = v(1, 0, 1, 8'h05, 0, 0,  1, 1, 4, 8'h05, 0, 0, 0, 0);
        vecs[8]  = v(1, 1, 0, 8'h77, 1, 0,  0, 0, 0, 8'h00, 1, 0, 4, 0); // START: input blocked, es ignored
        vecs[9]  = v(0, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 4, 0); // SORT, drain ignored
        vecs[10] = v(0, 0, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00, 0, 0, 4, 0); // sort done
        vecs[11] = v(0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 1, 4, 0); // pkt_ready pulse
        vecs[12] = v(1, 1, 0, 8'h55, 0, 0,  0, 0, 0, 8'h00, 0, 0, 4, 0); // HOLD blocks input
        vecs[13] = v(0, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 4, 0); // drained
        vecs[14] = v(1, 1, 1, 8'h07, 0, 0,  1, 1, 0, 8'h07, 0, 0, 4, 0); // 1-word pkt
        vecs[15] = v(0, 0, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00, 1, 0, 0, 0);
        vecs[16] = v(0, 0, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[17] = v(0, 0, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00, 0, 1, 0, 0); // 2 cycles after start
        vecs[18] = v(0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[19] = v(1, 1, 0, 8'h10, 0, 0,  1, 1, 0, 8'h10, 0, 0, 0, 0); // pkt then restart
        vecs[20] = v(1, 0, 0, 8'h11, 0, 0,  1, 1, 1, 8'h11, 0, 0, 0, 0);
        vecs[21] = v(1, 0, 0, 8'h12, 0, 0,  1, 1, 2, 8'h12, 0, 0, 0, 0);
        vecs[22] = v(1, 1, 0, 8'h20, 0, 0,  1, 1, 0, 8'h20, 0, 0, 0, 0); // sop mid-LOAD
        vecs[23] = v(1, 0, 1, 8'h21, 0, 0,  1, 1, 1, 8'h21, 0, 0, 0, 0);
        vecs[24] = v(0, 0, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00, 1, 0, 1, 0);
        vecs[25] = v(0, 0, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00, 0, 0, 1, 0);
        vecs[26] = v(0, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 1, 1, 0);
        vecs[27] = v(0, 0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0);

        drive(0, 0, 0, 8'h00, 0, 0);
        #1 arst_n_i = 1'b0;
        #2 chk_all_zero("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk_i);
            drive(vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].dat, vecs[i].es, vecs[i].dd);
            #1;
            chk($sformatf("r%0d.rdy", i),  32'(snk_if.snk_ready), 32'(vecs[i].rdy));
            chk($sformatf("r%0d.we", i),   32'(ram_we),           32'(vecs[i].we));
            chk($sformatf("r%0d.addr", i), 32'(ram_addr),         32'(vecs[i].addr));
            chk($sformatf("r%0d.data", i), 32'(ram_data),         32'(vecs[i].wdat));
            chk($sformatf("r%0d.st", i),   32'(start_sorting),    32'(vecs[i].st));
            chk($sformatf("r%0d.pr", i),   32'(pkt_ready),        32'(vecs[i].pr));
            chk($sformatf("r%0d.last", i), 32'(last_addr),        32'(vecs[i].last));
            chk($sformatf("r%0d.ovf", i),  32'(pkt_ovf),          32'(vecs[i].ovf));
        end

        // 20-word packet into a 16-word RAM: only indices 0..15 are written.
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            drive(1, i == 0, i == 19, 8'(i), 0, 0);
            #1;
            if (ram_we) writes++;
            chk($sformatf("ovf.we%0d", i), 32'(ram_we), (i < 16) ? 1 : 0);
            chk($sformatf("ovf.addr%0d", i), 32'(ram_addr), (i < 16) ? i : 0);
        end
        chk("ovf.writes", writes, 16);
        @(negedge clk_i);
        drive(0, 0, 0, 8'h00, 1, 0);
        #1;
        chk("ovf.st", 32'(start_sorting), 1);
        chk("ovf.last", 32'(last_addr), 15);
        chk("ovf.rdy", 32'(snk_if.snk_ready), 0);
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            #1;
            if (pkt_ready) begin
                lat = c;
                break;
            end
        end
        chk("ovf.pr_latency", lat, 2);
        chk("ovf.flag", 32'(pkt_ovf), 1);
        @(negedge clk_i);
        drive(0, 0, 0, 8'h00, 0, 1);
        @(negedge clk_i);
        drive(1, 1, 0, 8'h99, 0, 0);
        #1;
        chk("ovf.held_until_sop", 32'(pkt_ovf), 1);
        chk("ovf.next_addr", 32'(ram_addr), 0);
        chk("ovf.next_we", 32'(ram_we), 1);
        @(negedge clk_i);
        drive(1, 0, 0, 8'h9A, 0, 0);
        #1;
        chk("ovf.cleared", 32'(pkt_ovf), 0);
        chk("load.addr1", 32'(ram_addr), 1);

        // Async reset in the middle of a packet: outputs drop without a clock edge.
        #2 arst_n_i = 1'b0;
        #1 chk_all_zero("arst");
        @(negedge clk_i);
        drive(0, 0, 0, 8'h00, 0, 0);
        arst_n_i = 1'b1;
        @(negedge clk_i);
        #1 chk("arst.rdy_back", 32'(snk_if.snk_ready), 1);
        drive(1, 1, 0, 8'h40, 0, 0);
        #1;
        chk("arst.pkt_we", 32'(ram_we), 1);
        chk("arst.pkt_addr0", 32'(ram_addr), 0);
        chk("arst.pkt_data", 32'(ram_data), 32'h40);
        @(negedge clk_i);
        drive(1, 0, 1, 8'h41, 0, 0);
        #1 chk("arst.pkt_addr1", 32'(ram_addr), 1);
        @(negedge clk_i);
        drive(0, 0, 0, 8'h00, 0, 0);
        #1;
        chk("arst.st", 32'(start_sorting), 1);
        chk("arst.last", 32'(last_addr), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
